// File: rtl/ucc_pkg.sv
// Shared definitions for the UCC chain sequencer: chain mode codes, command
// op codes (identical to the modes) and the sequencer FSM state encoding.
package ucc_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_COUNT = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // An op code is driven straight onto chain_min while running.
  localparam logic [1:0] OP_HOLD  = MODE_HOLD;
  localparam logic [1:0] OP_COUNT = MODE_COUNT;
  localparam logic [1:0] OP_SHIFT = MODE_SHIFT;
  localparam logic [1:0] OP_LOAD  = MODE_LOAD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ucc_ctrl_if.sv
// Command handshake bundle for ucc_ctrl: the requester drives the command
// fields and valid, the sequencer answers with ready.
interface ucc_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_sin;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, cmd_sin,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, cmd_sin,
    output cmd_ready
  );
endinterface

// File: rtl/ucc_len_cnt.sv
// Remaining-cycle down-counter for the sequencer: loads the command length,
// decrements once per running cycle and flags the final cycle.
module ucc_len_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] rem_reg;

  // Saturates at zero so a stray decrement can never wrap to the maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg <= '0;
    end else if (load) begin
      rem_reg <= load_val;
    end else if (dec && (rem_reg != '0)) begin
      rem_reg <= rem_reg - 1'b1;
    end
  end

  assign last = (rem_reg == CNT_W'(1));

endmodule

// File: rtl/ucc_ctrl.sv
// Command sequencer driving a cascade of universal counter cells.
// Overflow detection is built only when UCC_CTRL_OVF_EN is defined.
module ucc_ctrl
  import ucc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  ucc_ctrl_if.slave        cmd,
  output logic [1:0]       chain_min,
  output logic             chain_cin,
  output logic             chain_fin,
  output logic [WIDTH-1:0] chain_pin,
  input  logic             chain_cout,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  input  logic             ovf_clr
);

  state_t           state_reg, state_next;
  logic [1:0]       op_reg, op_next;
  logic             sin_reg, sin_next;
  logic [WIDTH-1:0] pin_next;
  logic [1:0]       min_next;
  logic             cin_next, fin_next;
  logic             handshake;
  logic             cnt_last;

  assign handshake = (state_reg == IDLE) && cmd.cmd_valid;

  ucc_len_cnt #(.CNT_W(CNT_W)) u_len_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (handshake),
    .load_val (cmd.cmd_len),
    .dec      (state_reg == RUN),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= OP_HOLD;
      sin_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      sin_reg   <= sin_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    sin_next   = sin_reg;
    pin_next   = chain_pin;
    unique case (state_reg)
      IDLE: begin
        if (cmd.cmd_valid) begin
          op_next  = cmd.cmd_op;
          sin_next = cmd.cmd_sin;
          pin_next = cmd.cmd_data;
          // A zero-length timed op has nothing to drive and completes at once.
          if ((cmd.cmd_op != OP_LOAD) && (cmd.cmd_len == '0)) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if ((op_reg == OP_LOAD) || cnt_last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the upcoming state.
    min_next = (state_next == RUN) ? op_next : MODE_HOLD;
    cin_next = (state_next == RUN) && (op_next == OP_COUNT);
    fin_next = (state_next == RUN) && (op_next == OP_SHIFT) && sin_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_min     <= MODE_HOLD;
      chain_cin     <= 1'b0;
      chain_fin     <= 1'b0;
      chain_pin     <= '0;
      cmd.cmd_ready <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      chain_min     <= min_next;
      chain_cin     <= cin_next;
      chain_fin     <= fin_next;
      chain_pin     <= pin_next;
      cmd.cmd_ready <= (state_next == IDLE);
      busy          <= (state_next == RUN);
      done          <= (state_next == DONE);
    end
  end

`ifdef UCC_CTRL_OVF_EN
  logic ovf_reg;

  // Setting has priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if ((chain_min == MODE_COUNT) && chain_cin && chain_cout) begin
      ovf_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  assign ovf = ovf_reg;
`else
  logic unused_ovf_inputs;
  assign unused_ovf_inputs = chain_cout ^ ovf_clr;
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ucc_ctrl.sv
// Self-checking bench for ucc_ctrl: directed and random commands compared
// cycle by cycle against a per-command expected trace.
module tb_ucc_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       chain_min;
  logic             chain_cin, chain_fin;
  logic [WIDTH-1:0] chain_pin;
  logic             chain_cout;
  logic             busy, done, ovf, ovf_clr;

  int errors = 0;
  int checks = 0;
  logic             ovf_m;
  logic [WIDTH-1:0] pin_m;
  bit               plan_cout [0:511];
  bit               plan_clr  [0:511];

  ucc_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

  ucc_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .chain_min  (chain_min),
    .chain_cin  (chain_cin),
    .chain_fin  (chain_fin),
    .chain_pin  (chain_pin),
    .chain_cout (chain_cout),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [14:0] obs_vec();
    return {cmd_if.cmd_ready, busy, done, chain_min, chain_cin, chain_fin, chain_pin};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  task automatic clear_plan();
    for (int p = 0; p < 512; p++) begin
      plan_cout[p] = 1'b0;
      plan_clr[p]  = 1'b0;
    end
  endtask

  task automatic random_plan();
    for (int p = 0; p < 512; p++) begin
      plan_cout[p] = ($urandom_range(0, 3) == 0);
      plan_clr[p]  = ($urandom_range(0, 5) == 0);
    end
  endtask

  // Drive cout/clr for the current cycle and predict ovf after the next edge.
  task automatic apply_plan(input int p, input logic [1:0] cur_min, input logic cur_cin);
    chain_cout = plan_cout[p];
    ovf_clr    = plan_clr[p];
`ifdef UCC_CTRL_OVF_EN
    if (cur_min == 2'b01 && cur_cin && chain_cout) ovf_m = 1'b1;
    else if (ovf_clr) ovf_m = 1'b0;
`endif
  endtask

  task automatic run_cmd(input logic [1:0] op, input int len, input logic [7:0] data,
                         input logic sin, input int abort_at);
    int n;
    logic [14:0] exp;
    logic [1:0]  emin;
    logic        ecin, efin;
    chk("idle", 32'(obs_vec()), 32'({1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, pin_m}));
    chk("ovf_idle", 32'(ovf), 32'(ovf_m));
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_len   = CNT_W'(len);
    cmd_if.cmd_data  = data;
    cmd_if.cmd_sin   = sin;
    apply_plan(0, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    // Junk held valid while busy must be ignored.
    cmd_if.cmd_op   = 2'($urandom);
    cmd_if.cmd_len  = CNT_W'($urandom);
    cmd_if.cmd_data = WIDTH'($urandom);
    cmd_if.cmd_sin  = 1'($urandom);
    pin_m = data;
    n = (op == 2'b11) ? 1 : len;
    $display("cmd op=%0d len=%0d data=%h sin=%0d", op, len, data, sin);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k < n) begin
        emin = op;
        ecin = (op == 2'b01);
        efin = (op == 2'b10) && sin;
        exp  = {1'b0, 1'b1, 1'b0, emin, ecin, efin, pin_m};
      end else begin
        emin = 2'b00;
        ecin = 1'b0;
        efin = 1'b0;
        exp  = {1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, pin_m};
        cmd_if.cmd_valid = 1'b0;
      end
      chk((k < n) ? "drive" : "done", 32'(obs_vec()), 32'(exp));
      chk("ovf", 32'(ovf), 32'(ovf_m));
      if (k == abort_at) begin
        #2 rst = 1'b1;
        ovf_m = 1'b0;
        pin_m = '0;
        cmd_if.cmd_valid = 1'b0;
        #1;
        chk("rst_async", 32'(obs_vec()), 32'({1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00}));
        chk("rst_ovf", 32'(ovf), 32'(1'b0));
        chain_cout = 1'b0;
        ovf_clr    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      apply_plan(k + 1, emin, ecin);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_len   = '0;
    cmd_if.cmd_data  = '0;
    cmd_if.cmd_sin   = 1'b0;
    chain_cout = 1'b0;
    ovf_clr    = 1'b0;
    ovf_m = 1'b0;
    pin_m = '0;
    clear_plan();

    @(posedge clk);
    @(negedge clk);
    chk("reset", 32'(obs_vec()), 32'({1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00}));
    chk("reset_ovf", 32'(ovf), 32'(1'b0));
    rst = 1'b0;
    @(negedge clk);

    run_cmd(2'b11, 0, 8'hA5, 1'b0, -1);
    run_cmd(2'b01, 5, 8'h3C, 1'b0, -1);

    // cout on the 3rd count cycle, then set+clear together, then clear alone.
    clear_plan();
    plan_cout[3] = 1'b1;
    plan_cout[5] = 1'b1;
    plan_clr[5]  = 1'b1;
    plan_clr[6]  = 1'b1;
    run_cmd(2'b01, 6, 8'h11, 1'b0, -1);
    clear_plan();

    run_cmd(2'b10, 3, 8'h22, 1'b1, -1);
    run_cmd(2'b00, 0, 8'h33, 1'b0, -1);
    run_cmd(2'b01, 0, 8'h44, 1'b0, -1);
    run_cmd(2'b11, 7, 8'h5A, 1'b1, -1);
    run_cmd(2'b00, 4, 8'h66, 1'b1, -1);
    run_cmd(2'b01, 255, 8'h77, 1'b0, -1);

    // Reset during the 2nd count cycle: no done, then immediate acceptance.
    run_cmd(2'b01, 10, 8'h88, 1'b0, 1);
    chk("post_rst_done", 32'(done), 32'(1'b0));
    run_cmd(2'b01, 2, 8'h99, 1'b0, -1);

    for (int i = 0; i < 30; i++) begin
      random_plan();
      run_cmd(2'($urandom), ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12)),
              8'($urandom), 1'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
